countdown_sequencer: RTL and testbench
======================================

// Module: countdown_sequencer
// PURPOSE
//  Loadable down-counter with a small FSM. It is the consumer-side counterpart of the free-running up-counter.
//  - Accepts an element count over a valid/ready load handshake.
//  - Decrements once per step strobe and pulses done when the count is exhausted.
//  - Sits in the vector datapath and sequences per-element operations for one vector instruction.
// PARAMETERS
//  WIDTH      4            width of the count and load value
//  MAX_COUNT  2**WIDTH-1   largest accepted load value; larger loads are clamped to it
// PORTS
//  clk         in   1      rising-edge clock
//  reset_n     in   1      asynchronous reset, active-low
//  load_valid  in   1      load_count is valid
//  load_ready  out  1      block can accept a load (high only in IDLE)
//  load_count  in   WIDTH  number of elements to sequence
//  step        in   1      one element consumed this cycle
//  abort       in   1      synchronous cancel of the current sequence
//  count       out  WIDTH  elements remaining
//  busy        out  1      high in RUN
//  last        out  1      high in RUN when count==1
//  done        out  1      one-cycle pulse after the final step or a zero-length load
// BEHAVIOUR
//  Reset (async, reset_n=0), from any state including mid-RUN:
//  - state=IDLE, count=0, done=0, busy=0, last=0, load_ready=1.
//  States: IDLE, RUN, DONE. All transitions occur on the rising clk edge.
//  IDLE:
//  - load_ready=1.
//  - On load_valid, count<=min(load_count,MAX_COUNT).
//  - If the loaded value is nonzero, next state is RUN.
//  - If the loaded value is 0, count stays 0 and next state is DONE (zero-length vector).
//  - step is ignored in IDLE.
//  RUN:
//  - load_ready=0; load_valid is ignored.
//  - On step, count<=count-1.
//  - On step with count==1, count<=0 and next state is DONE.
//  - Without step, count holds.
//  DONE:
//  - done=1 for exactly one cycle; then IDLE.
//  - step and load_valid are ignored in DONE; the new load is taken the following cycle.
//  Abort:
//  - In RUN: count<=0, next state IDLE, no done pulse.
//  - abort beats step when both are high in the same cycle.
//  - abort is ignored in IDLE and DONE.
//  Outputs:
//  - done, busy and last are decoded from the registered state and count. They are glitch-free.
//  - Latency from the final step edge to done=1 is 1 cycle.
//  Arithmetic:
//  - Decrement is WIDTH-bit unsigned. count never wraps below 0, because RUN exits at 1->0.
//  - A loaded value of MAX_COUNT decrements normally.
// TESTING
//  1. Reset: hold reset_n=0 mid-RUN (count=5) -> count=0, state IDLE, load_ready=1 asynchronously, no done.
//  2. Load 3, step every cycle -> count 3,2,1,0. last=1 while count==1; done pulses 1 cycle after the 3rd step; then IDLE.
//  3. Load 0 -> DONE on the next edge, done=1 for one cycle, busy never asserted.
//  4. Load 15 (WIDTH=4), step gapped every other cycle -> count holds on gaps; done after 15 steps; no wrap to 15.
//  5. Load 4, two steps, then abort+step in the same cycle -> count=0, IDLE, done stays 0.
//  6. load_valid held high in DONE with load_count=2 -> ignored in DONE; loaded the next cycle in IDLE; count=2, busy=1.

Source files
------------

// File: rtl/countdown_sequencer.sv
// Loadable down-counter sequencing the per-element operations of one vector instruction.
// It takes an element count, decrements it once per step and pulses done when the count is exhausted.
module countdown_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_count,
  input  logic             step,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Load handshake: a load is taken on a rising edge where load_valid && load_ready;
  // load_ready is high only in IDLE, and load_valid is ignored whenever load_ready is low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_load_val;

  assign w_load_val = (load_count > MAX_VAL) ? MAX_VAL : load_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_next_count = w_load_val;
          w_next_state = (w_load_val == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort takes priority over a step in the same cycle
        if (abort) begin
          w_next_count = '0;
          w_next_state = S_IDLE;
        end else if (step) begin
          w_next_count = r_count - 1'b1;
          if (r_count == WIDTH'(1)) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  always_comb begin
    load_ready = (r_state == S_IDLE);
    busy       = (r_state == S_RUN);
    last       = (r_state == S_RUN) && (r_count == WIDTH'(1));
    done       = (r_state == S_DONE);
    count      = r_count;
    state_dbg  = r_state;
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: one task per scenario, each with inline checks
// of the packed observation {count, busy, last, done, load_ready, state}.
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_count;
  logic       step;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       last;
  logic       done;
  logic [1:0] state_dbg;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [9:0] w_obs;
  logic [9:0] e;

  assign w_obs = {count, busy, last, done, load_ready, state_dbg};

  countdown_sequencer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_count (load_count),
    .step       (step),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .last       (last),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Expected observation encodings: IDLE=0, RUN=1, DONE=2
  function automatic logic [9:0] exp_idle(input logic [3:0] c);
    return {c, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
  endfunction

  function automatic logic [9:0] exp_run(input logic [3:0] c, input logic l);
    return {c, 1'b1, l, 1'b0, 1'b0, 2'd1};
  endfunction

  function automatic logic [9:0] exp_done();
    return {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_count = 4'd0;
    step       = 1'b0;
    abort      = 1'b0;
    #2;
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL reset_initial got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    // load 5, step twice would be 3; keep it at 5 and reset mid-RUN
    load_valid = 1'b1;
    load_count = 4'd5;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd5, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL reset_load5 got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    #3;
    reset_n = 1'b0;
    #1;
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL reset_async_midrun got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    #2;
    reset_n = 1'b1;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL reset_after_release got=%h exp=%h", w_obs, e);
    else pass_cnt++;
  endtask

  task automatic test_count3();
    load_valid = 1'b1;
    load_count = 4'd3;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd3, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL cnt3_load got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b1;
    tick();
    e = exp_run(4'd2, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL cnt3_step1 got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    tick();
    e = exp_run(4'd1, 1'b1);
    check_cnt++;
    if (w_obs !== e) $display("FAIL cnt3_step2_last got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    tick();
    e = exp_done();
    check_cnt++;
    if (w_obs !== e) $display("FAIL cnt3_done got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b0;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL cnt3_idle got=%h exp=%h", w_obs, e);
    else pass_cnt++;
  endtask

  task automatic test_zero_load();
    load_valid = 1'b1;
    load_count = 4'd0;
    tick();
    load_valid = 1'b0;
    e = exp_done();
    check_cnt++;
    if (w_obs !== e) $display("FAIL zero_done got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL zero_idle got=%h exp=%h", w_obs, e);
    else pass_cnt++;
  endtask

  task automatic test_gapped_max();
    load_valid = 1'b1;
    load_count = 4'd15;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd15, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL max_load got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    for (int k = 1; k <= 15; k++) begin
      step = 1'b1;
      tick();
      if (k == 15) e = exp_done();
      else         e = exp_run(4'(15 - k), (k == 14));
      check_cnt++;
      if (w_obs !== e) $display("FAIL max_step%0d got=%h exp=%h", k, w_obs, e);
      else pass_cnt++;
      step = 1'b0;
      tick();
      if (k == 15) e = exp_idle(4'd0);
      else         e = exp_run(4'(15 - k), (k == 14));
      check_cnt++;
      if (w_obs !== e) $display("FAIL max_gap%0d got=%h exp=%h", k, w_obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    load_valid = 1'b1;
    load_count = 4'd4;
    tick();
    load_valid = 1'b0;
    step = 1'b1;
    tick();
    tick();
    e = exp_run(4'd2, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL abort_two_steps got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL abort_with_step got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b0;
    abort = 1'b0;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL abort_no_done got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    // abort in IDLE does not block a load
    abort = 1'b1;
    load_valid = 1'b1;
    load_count = 4'd2;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd2, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL abort_ignored_idle got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    tick();
    abort = 1'b0;
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL abort_no_step got=%h exp=%h", w_obs, e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load_valid = 1'b1;
    load_count = 4'd1;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd1, 1'b1);
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_load1 got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b1;
    load_valid = 1'b1;
    load_count = 4'd7;
    tick();
    e = exp_done();
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_done_run_load_ignored got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b0;
    load_count = 4'd2;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_done_load_ignored got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    tick();
    load_valid = 1'b0;
    e = exp_run(4'd2, 1'b0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_loaded_in_idle got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b1;
    tick();
    tick();
    e = exp_done();
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_second_done got=%h exp=%h", w_obs, e);
    else pass_cnt++;
    step = 1'b0;
    tick();
    e = exp_idle(4'd0);
    check_cnt++;
    if (w_obs !== e) $display("FAIL b2b_final_idle got=%h exp=%h", w_obs, e);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_zero_load();
    test_gapped_max();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
